// File: rtl/mem_access_stage_pkg.sv
// Shared constants and types for the MEM stage: NOP word, FSM encoding, field widths.
package mem_access_stage_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int WADDR_W_DEF = 9;
  localparam int PC_W        = 9;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [31:0] NOP_INST = 32'h0000_0020;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register; a bubble loads a NOP with every other field cleared.
module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int          WADDR_W = WADDR_W_DEF,
  parameter logic [31:0] NOP     = NOP_INST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bubble,
  input  logic               regwrite_in,
  input  logic [WADDR_W-1:0] wraddr_in,
  input  logic [31:0]        wdata_in,
  input  logic [PC_W-1:0]    pc_4_in,
  input  logic [31:0]        inst_in,
  output logic               WB_regwrite,
  output logic [WADDR_W-1:0] WB_wraddr,
  output logic [31:0]        WB_wdata,
  output logic [PC_W-1:0]    WB_pc_4,
  output logic [31:0]        WB_inst
);

  logic               regwrite_d, regwrite_q;
  logic [WADDR_W-1:0] wraddr_d, wraddr_q;
  logic [31:0]        wdata_d, wdata_q;
  logic [PC_W-1:0]    pc_4_d, pc_4_q;
  logic [31:0]        inst_d, inst_q;

  always_comb begin
    regwrite_d = regwrite_in;
    wraddr_d   = wraddr_in;
    wdata_d    = wdata_in;
    pc_4_d     = pc_4_in;
    inst_d     = inst_in;
    if (bubble) begin
      regwrite_d = 1'b0;
      wraddr_d   = '0;
      wdata_d    = '0;
      pc_4_d     = '0;
      inst_d     = NOP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q <= 1'b0;
      wraddr_q   <= '0;
      wdata_q    <= '0;
      pc_4_q     <= '0;
      inst_q     <= NOP;
    end else begin
      regwrite_q <= regwrite_d;
      wraddr_q   <= wraddr_d;
      wdata_q    <= wdata_d;
      pc_4_q     <= pc_4_d;
      inst_q     <= inst_d;
    end
  end

  assign WB_regwrite = regwrite_q;
  assign WB_wraddr   = wraddr_q;
  assign WB_wdata    = wdata_q;
  assign WB_pc_4     = pc_4_q;
  assign WB_inst     = inst_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: drives a req/ack data-memory bus, stalls the pipe while an access is
// outstanding, and feeds the MEM/WB register with the selected write-back value.
//   state | meaning
//   IDLE  | no access outstanding; non-memory instructions pass straight to WB
//   BUSY  | dm_req held, waiting for dm_ack or timeout
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int          ADDR_W  = ADDR_W_DEF,
  parameter int          WADDR_W = WADDR_W_DEF,
  parameter int          TIMEOUT = TIMEOUT_DEF,
  parameter logic [31:0] NOP     = NOP_INST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               MEM_memread,
  input  logic               MEM_memwrite,
  input  logic               MEM_memtoreg,
  input  logic               MEM_regwrite,
  input  logic               MEM_link,
  input  logic [31:0]        MEM_data_in,
  input  logic [31:0]        MEM_address_in,
  input  logic [WADDR_W-1:0] MEM_wraddr,
  input  logic [PC_W-1:0]    MEM_pc_4,
  input  logic [31:0]        MEM_inst,
  output logic               dm_req,
  output logic               dm_we,
  output logic [ADDR_W-1:0]  dm_addr,
  output logic [31:0]        dm_wdata,
  input  logic               dm_ack,
  input  logic [31:0]        dm_rdata,
  output logic               mem_stall,
  output logic               bus_err,
  output logic               WB_regwrite,
  output logic [WADDR_W-1:0] WB_wraddr,
  output logic [31:0]        WB_wdata,
  output logic [PC_W-1:0]    WB_pc_4,
  output logic [31:0]        WB_inst
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_e        state_d, state_q;
  logic              req_d, req_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [31:0]       wdata_d, wdata_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              kill_d, kill_q;
  logic              bus_err_d, bus_err_q;

  logic        memop, capture, timeout, killed, bubble;
  logic [31:0] wb_value;

  assign memop = (MEM_memread | MEM_memwrite) & ~flush;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    bus_err_d = bus_err_q;
    mem_stall = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall = memop;
        if (memop) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MEM_memwrite & ~MEM_memread;
          addr_d  = MEM_address_in[ADDR_W+1:2];
          wdata_d = MEM_data_in;
          cnt_d   = '0;
          kill_d  = 1'b0;
        end else begin
          capture = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) kill_d = 1'b1;
        if (dm_ack) begin
          capture = 1'b1;
          state_d = IDLE;
          req_d   = 1'b0;
          kill_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          capture   = 1'b1;
          state_d   = IDLE;
          req_d     = 1'b0;
          kill_d    = 1'b0;
          bus_err_d = 1'b1;
        end
        mem_stall = ~capture;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      kill_q    <= kill_d;
      bus_err_q <= bus_err_d;
    end
  end

  // a flush in the completing cycle kills just like one latched earlier in BUSY
  assign killed = flush | ((state_q == BUSY) & kill_q);
  // while stalled the instruction is still held upstream, so WB sees bubbles
  assign bubble = ~capture | killed;

  always_comb begin
    wb_value = MEM_address_in;
    if (MEM_link)          wb_value = {{(32-PC_W){1'b0}}, MEM_pc_4};
    else if (MEM_memtoreg) wb_value = dm_rdata;
  end

  mem_wb_reg #(
    .WADDR_W (WADDR_W),
    .NOP     (NOP)
  ) u_mem_wb (
    .clk         (clk),
    .rst_n       (rst_n),
    .bubble      (bubble),
    .regwrite_in (MEM_regwrite & ~timeout),
    .wraddr_in   (MEM_wraddr),
    .wdata_in    (wb_value),
    .pc_4_in     (MEM_pc_4),
    .inst_in     (MEM_inst),
    .WB_regwrite (WB_regwrite),
    .WB_wraddr   (WB_wraddr),
    .WB_wdata    (WB_wdata),
    .WB_pc_4     (WB_pc_4),
    .WB_inst     (WB_inst)
  );

  assign dm_req   = req_q;
  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: expected WB records are queued when an
// instruction is driven and compared when the stage retires it.
module tb_mem_access_stage;

  localparam logic [31:0] NOPW = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        MEM_memread = 1'b0, MEM_memwrite = 1'b0, MEM_memtoreg = 1'b0;
  logic        MEM_regwrite = 1'b0, MEM_link = 1'b0;
  logic [31:0] MEM_data_in = '0, MEM_address_in = '0, MEM_inst = NOPW;
  logic [8:0]  MEM_wraddr = '0, MEM_pc_4 = '0;
  logic        dm_req, dm_we, dm_ack = 1'b0;
  logic [8:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata = '0;
  logic        mem_stall, bus_err;
  logic        WB_regwrite;
  logic [8:0]  WB_wraddr, WB_pc_4;
  logic [31:0] WB_wdata, WB_inst;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rw;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic [8:0]  pc;
    logic [31:0] inst;
  } wb_t;

  wb_t sb_q[$];
  wb_t exp_r, act_r;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite), .MEM_memtoreg(MEM_memtoreg),
    .MEM_regwrite(MEM_regwrite), .MEM_link(MEM_link), .MEM_data_in(MEM_data_in),
    .MEM_address_in(MEM_address_in), .MEM_wraddr(MEM_wraddr), .MEM_pc_4(MEM_pc_4),
    .MEM_inst(MEM_inst), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mem_stall(mem_stall),
    .bus_err(bus_err), .WB_regwrite(WB_regwrite), .WB_wraddr(WB_wraddr),
    .WB_wdata(WB_wdata), .WB_pc_4(WB_pc_4), .WB_inst(WB_inst)
  );

  always #5 clk = ~clk;

  function automatic wb_t wb_now();
    return {WB_regwrite, WB_wraddr, WB_wdata, WB_pc_4, WB_inst};
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic lk, input logic [31:0] data, input logic [31:0] addr,
                       input logic [8:0] wa, input logic [8:0] pc, input logic [31:0] inst);
    MEM_memread = rd; MEM_memwrite = wr; MEM_memtoreg = m2r; MEM_regwrite = rw;
    MEM_link = lk; MEM_data_in = data; MEM_address_in = addr; MEM_wraddr = wa;
    MEM_pc_4 = pc; MEM_inst = inst;
  endtask

  task automatic drive_nop();
    drive(0, 0, 0, 0, 0, '0, '0, '0, '0, NOPW);
    flush = 1'b0;
    dm_ack = 1'b0;
  endtask

  // Called at a negedge with a memory op already driven; returns at the negedge after
  // dm_req has dropped (or when the cycle budget runs out).
  task automatic run_access(input int ack_after, input int flush_at, input logic [31:0] rdata,
                            output int stalls, output int reqs, output bit unstable,
                            output bit hung, output logic [8:0] a0, output logic w0,
                            output logic [31:0] d0);
    bit seen = 0;
    stalls = 0; reqs = 0; unstable = 0; hung = 1; a0 = '0; w0 = 0; d0 = '0;
    for (int c = 0; c < 300; c++) begin
      if (c >= 1 && !dm_req) begin
        hung = 0;
        break;
      end
      if (dm_req) begin
        reqs++;
        if (!seen) begin
          seen = 1; a0 = dm_addr; w0 = dm_we; d0 = dm_wdata;
        end else if ({dm_addr, dm_we, dm_wdata} !== {a0, w0, d0}) begin
          unstable = 1;
        end
      end
      dm_ack   = (c >= 1 && (c - 1) == ack_after);
      dm_rdata = rdata;
      flush    = (c == flush_at);
      #1;
      if (mem_stall) stalls++;
      @(negedge clk);
    end
    dm_ack = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic test_reset();
    drive_nop();
    repeat (2) @(negedge clk);
    act_r = wb_now();
    checks++;
    if (act_r !== {1'b0, 9'h0, 32'h0, 9'h0, NOPW}) begin
      errors++; $display("FAIL reset_wb: got %h expected %h", act_r, {1'b0, 9'h0, 32'h0, 9'h0, NOPW});
    end
    checks++;
    if ({dm_req, dm_we, dm_addr, dm_wdata, bus_err, mem_stall} !== '0) begin
      errors++; $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h err=%b stall=%b expected all 0",
                         dm_req, dm_we, dm_addr, dm_wdata, bus_err, mem_stall);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 32'h0, 32'h1234, 9'd5, 9'h010, 32'h0123_4567);
    sb_q.push_back({1'b1, 9'd5, 32'h1234, 9'h010, 32'h0123_4567});
    #1;
    checks++;
    if (dm_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL alu_no_req: got req=%b stall=%b expected 0 0", dm_req, mem_stall);
    end
    @(negedge clk);
    drive_nop();
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL alu_wb: got %h expected %h", act_r, exp_r);
    end
  endtask

  task automatic test_load();
    int st, rq; bit un, hg; logic [8:0] a0; logic w0; logic [31:0] d0;
    @(negedge clk);
    drive(1, 0, 1, 1, 0, 32'h0, 32'h0000_0010, 9'd7, 9'h020, 32'h8C07_0010);
    sb_q.push_back({1'b1, 9'd7, 32'hDEAD_BEEF, 9'h020, 32'h8C07_0010});
    run_access(3, -1, 32'hDEAD_BEEF, st, rq, un, hg, a0, w0, d0);
    drive_nop();
    checks++;
    if (hg) begin errors++; $display("FAIL load_done: got no completion expected dm_req drop"); end
    checks++;
    if (a0 !== 9'd4 || w0 !== 1'b0 || un) begin
      errors++; $display("FAIL load_bus: got addr=%h we=%b unstable=%b expected 004 0 0", a0, w0, un);
    end
    checks++;
    if (st !== 4 || rq !== 4) begin
      errors++; $display("FAIL load_stall: got stall=%0d req=%0d expected 4 4", st, rq);
    end
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL load_wb: got %h expected %h", act_r, exp_r);
    end
  endtask

  task automatic test_store();
    int st, rq; bit un, hg; logic [8:0] a0; logic w0; logic [31:0] d0;
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 32'hA5A5_A5A5, 32'h0000_0040, 9'd0, 9'h030, 32'hAC08_0040);
    sb_q.push_back({1'b0, 9'd0, 32'h0000_0040, 9'h030, 32'hAC08_0040});
    run_access(0, -1, 32'h1111_2222, st, rq, un, hg, a0, w0, d0);
    drive_nop();
    checks++;
    if (hg || a0 !== 9'h010 || w0 !== 1'b1 || d0 !== 32'hA5A5_A5A5 || un) begin
      errors++; $display("FAIL store_bus: got hung=%b addr=%h we=%b wdata=%h unstable=%b expected 0 010 1 a5a5a5a5 0",
                         hg, a0, w0, d0, un);
    end
    checks++;
    if (st !== 1) begin errors++; $display("FAIL store_stall: got %0d expected 1", st); end
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL store_wb: got %h expected %h", act_r, exp_r);
    end
  endtask

  task automatic test_jal();
    @(negedge clk);
    drive(0, 0, 1, 1, 1, 32'h0, 32'h5555_5555, 9'd31, 9'h104, 32'h0C00_0040);
    sb_q.push_back({1'b1, 9'd31, 32'h0000_0104, 9'h104, 32'h0C00_0040});
    @(negedge clk);
    drive_nop();
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL jal_wb: got %h expected %h", act_r, exp_r);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    drive(1, 0, 1, 1, 0, 32'h0, 32'h0000_0080, 9'd9, 9'h044, 32'h8C09_0080);
    flush = 1'b1;
    sb_q.push_back({1'b0, 9'h0, 32'h0, 9'h0, NOPW});
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b expected 0", mem_stall); end
    @(negedge clk);
    drive_nop();
    checks++;
    if (dm_req !== 1'b0) begin errors++; $display("FAIL flush_idle_req: got %b expected 0", dm_req); end
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL flush_idle_wb: got %h expected %h", act_r, exp_r);
    end
  endtask

  task automatic test_flush_busy();
    int st, rq; bit un, hg; logic [8:0] a0; logic w0; logic [31:0] d0;
    @(negedge clk);
    drive(1, 0, 1, 1, 0, 32'h0, 32'h0000_0020, 9'd12, 9'h050, 32'h8C0C_0020);
    sb_q.push_back({1'b0, 9'h0, 32'h0, 9'h0, NOPW});
    run_access(4, 2, 32'hCAFE_F00D, st, rq, un, hg, a0, w0, d0);
    drive_nop();
    checks++;
    if (hg || rq !== 5 || un) begin
      errors++; $display("FAIL flush_busy_bus: got hung=%b req=%0d unstable=%b expected 0 5 0", hg, rq, un);
    end
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL flush_busy_wb: got %h expected %h", act_r, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 32'h0, 32'hAAAA_0001, 9'd1, 9'h060, 32'h0000_1001);
    sb_q.push_back({1'b1, 9'd1, 32'hAAAA_0001, 9'h060, 32'h0000_1001});
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 32'h0, 32'hBBBB_0002, 9'd2, 9'h064, 32'h0000_1002);
    sb_q.push_back({1'b1, 9'd2, 32'hBBBB_0002, 9'h064, 32'h0000_1002});
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if (act_r !== exp_r) begin errors++; $display("FAIL b2b_first: got %h expected %h", act_r, exp_r); end
    @(negedge clk);
    drive_nop();
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if (act_r !== exp_r) begin errors++; $display("FAIL b2b_second: got %h expected %h", act_r, exp_r); end
  endtask

  task automatic test_timeout();
    int st, rq; bit un, hg; logic [8:0] a0; logic w0; logic [31:0] d0;
    @(negedge clk);
    drive(1, 0, 1, 1, 0, 32'h0, 32'h0000_0100, 9'd3, 9'h070, 32'h8C03_0100);
    sb_q.push_back({1'b0, 9'd3, 32'h0, 9'h070, 32'h8C03_0100});
    run_access(-1, -1, 32'h0, st, rq, un, hg, a0, w0, d0);
    drive_nop();
    checks++;
    if (hg || rq !== 64 || st !== 64) begin
      errors++; $display("FAIL timeout_len: got hung=%b req=%0d stall=%0d expected 0 64 64", hg, rq, st);
    end
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", bus_err); end
    exp_r = sb_q.pop_front(); act_r = wb_now();
    checks++;
    if ({act_r.rw, act_r.wa, act_r.inst} !== {exp_r.rw, exp_r.wa, exp_r.inst}) begin
      errors++; $display("FAIL timeout_wb: got rw=%b wa=%h inst=%h expected rw=%b wa=%h inst=%h",
                         act_r.rw, act_r.wa, act_r.inst, exp_r.rw, exp_r.wa, exp_r.inst);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", bus_err); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    drive(1, 0, 1, 1, 0, 32'h0, 32'h0000_0200, 9'd4, 9'h080, 32'h8C04_0200);
    dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dm_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got req=%b expected 1", dm_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dm_req !== 1'b0 || bus_err !== 1'b0 || WB_inst !== NOPW) begin
      errors++; $display("FAIL rst_mid: got req=%b err=%b inst=%h expected 0 0 %h", dm_req, bus_err, WB_inst, NOPW);
    end
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    test_alu();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_jal();
    test_flush_idle();
    test_flush_busy();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
